// File: rtl/inst_issue_arbiter_pkg.sv
// Shared types for the instruction issue arbiter: control bundles, FIFO slot
// payload and the issue state encoding.
package inst_issue_arbiter_pkg;

  localparam int unsigned INST_W  = 32;
  localparam int unsigned COUNT_W = 32;

  typedef struct packed {
    logic clk;
    logic rst;
  } global_t;

  typedef struct packed {
    logic flush;
  } local_t;

  typedef struct packed {
    logic              inst_en;
    logic [INST_W-1:0] inst;
  } inst_fifo_slot_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } issue_state_e;

endpackage

// File: rtl/inst_issue_arbiter_if.sv
// FIFO-side and FU-side signals of the issue arbiter; master is the arbiter.
interface inst_issue_arbiter_if #(
  parameter int unsigned NUM_Q = 4
);
  import inst_issue_arbiter_pkg::*;

  localparam int unsigned QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

  logic [NUM_Q-1:0]            q_empty;
  logic [NUM_Q-1:0]            q_ready;
  inst_fifo_slot_t [NUM_Q-1:0] q_top;
  logic [NUM_Q-1:0]            q_re;
  logic                        issue_valid;
  inst_fifo_slot_t             issue_slot;
  logic [QID_W-1:0]            issue_qid;
  logic                        fu_ready;

  modport master (
    input  q_empty, q_ready, q_top, fu_ready,
    output q_re, issue_valid, issue_slot, issue_qid
  );

  modport slave (
    output q_empty, q_ready, q_top, fu_ready,
    input  q_re, issue_valid, issue_slot, issue_qid
  );

endinterface

// File: rtl/inst_issue_arbiter_rr_arbiter.sv
// Round-robin picker with a forced-priority override (lowest forced index wins).
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  force_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_id_o,
  output logic          any_o
);

  logic [N-1:0] forced;
  logic         found;
  int unsigned  idx;

  always_comb begin
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    forced   = req_i & force_i;
    if (|forced) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (forced[IW'(i)] && !found) begin
          gnt_id_o = IW'(i);
          found    = 1'b1;
        end
      end
    end else begin
      // Search starts at the pointer and wraps.
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr_i) + k) % N;
        if (req_i[IW'(idx)] && !found) begin
          gnt_id_o = IW'(idx);
          found    = 1'b1;
        end
      end
    end
  end

  assign any_o = |req_i;
  assign gnt_o = any_o ? (N'(1) << gnt_id_o) : '0;

endmodule

// File: rtl/inst_issue_arbiter.sv
// Issues one eligible instruction-FIFO top slot per cycle into a registered
// valid/ready output stage; round robin with a starvation override.
module inst_issue_arbiter
  import inst_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_Q        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  local_t               cntl_i,
  inst_issue_arbiter_if.master bus,
  output logic [COUNT_W-1:0]   issue_count_o
);

  localparam int unsigned QID_W = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
  localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

  issue_state_e     state_q, state_d;
  logic [QID_W-1:0] ptr_q, ptr_d;
  logic [SW-1:0]    starve_q [NUM_Q];
  logic [SW-1:0]    starve_d [NUM_Q];
  logic             issue_valid_q, issue_valid_d;
  inst_fifo_slot_t  issue_slot_q, issue_slot_d;
  logic [QID_W-1:0] issue_qid_q, issue_qid_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic [NUM_Q-1:0] eligible, force_v, gnt, q_re_c;
  logic [QID_W-1:0] gnt_id;
  logic             any, slot_free, accept, pop, load;

  always_comb begin
    eligible = '0;
    force_v  = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      eligible[i] = !bus.q_empty[i] & (bus.q_ready[i] | !bus.q_top[i].inst_en);
      force_v[i]  = (starve_q[i] == SW'(STARVE_LIMIT));
    end
  end

  rr_arbiter #(.N(NUM_Q)) u_rr (
    .req_i    (eligible),
    .ptr_i    (ptr_q),
    .force_i  (force_v),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (any)
  );

  // HOLD may grant as soon as FU_Ready frees the slot, so restart has no bubble.
  always_comb begin
    slot_free = !issue_valid_q | bus.fu_ready;
    accept    = issue_valid_q & bus.fu_ready;
    pop       = any & slot_free & !cntl_i.flush & !rst & (state_q != FLUSH);
    load      = pop & bus.q_top[gnt_id].inst_en;
    q_re_c    = pop ? gnt : '0;
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    starve_d      = starve_q;
    issue_valid_d = issue_valid_q;
    issue_slot_d  = issue_slot_q;
    issue_qid_d   = issue_qid_q;
    count_d       = count_q;
    if (cntl_i.flush) begin
      state_d       = FLUSH;
      issue_valid_d = 1'b0;
      ptr_d         = '0;
      for (int i = 0; i < NUM_Q; i++) starve_d[i] = '0;
    end else begin
      case (state_q)
        RUN:     if (issue_valid_q && !bus.fu_ready) state_d = HOLD;
        HOLD:    if (bus.fu_ready) state_d = RUN;
        FLUSH:   state_d = RUN;
        default: state_d = RUN;
      endcase
      if (accept) count_d = count_q + COUNT_W'(1);
      if (load) begin
        issue_slot_d  = bus.q_top[gnt_id];
        issue_qid_d   = gnt_id;
        issue_valid_d = 1'b1;
      end else if (accept) begin
        issue_valid_d = 1'b0;
      end
      if (pop) ptr_d = QID_W'((32'(gnt_id) + 32'd1) % NUM_Q);
      for (int i = 0; i < NUM_Q; i++) begin
        if ((pop && gnt[i]) || !eligible[i]) begin
          starve_d[i] = '0;
        end else if (slot_free && (starve_q[i] != SW'(STARVE_LIMIT))) begin
          starve_d[i] = starve_q[i] + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      ptr_q         <= '0;
      issue_valid_q <= 1'b0;
      issue_slot_q  <= '0;
      issue_qid_q   <= '0;
      count_q       <= '0;
      for (int i = 0; i < NUM_Q; i++) starve_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      issue_valid_q <= issue_valid_d;
      issue_slot_q  <= issue_slot_d;
      issue_qid_q   <= issue_qid_d;
      count_q       <= count_d;
      starve_q      <= starve_d;
    end
  end

  assign bus.q_re        = q_re_c;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_slot  = issue_slot_q;
  assign bus.issue_qid   = issue_qid_q;
  assign issue_count_o   = count_q;

endmodule

// File: tb/tb_inst_issue_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_inst_issue_arbiter;
  import inst_issue_arbiter_pkg::*;

  localparam int unsigned NQ  = 4;
  localparam int unsigned LIM = 3;

  logic        clk = 1'b0;
  logic        rst;
  local_t      cntl;
  logic [31:0] issue_count;

  inst_issue_arbiter_if #(.NUM_Q(NQ)) bus ();

  inst_issue_arbiter #(.NUM_Q(NQ), .STARVE_LIMIT(LIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .cntl_i        (cntl),
    .bus           (bus),
    .issue_count_o (issue_count)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit              m_valid;
  inst_fifo_slot_t m_slot;
  int unsigned     m_qid, m_ptr;
  logic [31:0]     m_count;
  int unsigned     m_starve [NQ];
  bit              m_after_flush;

  logic [NQ-1:0]   s_qre, exp_qre;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic drive(input logic [NQ-1:0] empty, input logic [NQ-1:0] ready,
                       input logic [NQ-1:0] en);
    bus.q_empty = empty;
    bus.q_ready = ready;
    for (int i = 0; i < NQ; i++) begin
      bus.q_top[i].inst_en = en[i];
      bus.q_top[i].inst    = $urandom();
    end
  endtask

  // One clock: predict the pop from the rules, sample Q_Re, advance the model.
  task automatic tick();
    bit elig [NQ];
    inst_fifo_slot_t c_top [NQ];
    bit sf, found, pop, acc, c_rst, c_flush, c_fu;
    int unsigned g;
    #2;
    c_rst = rst; c_flush = cntl.flush; c_fu = bus.fu_ready;
    for (int i = 0; i < NQ; i++) begin
      c_top[i] = bus.q_top[i];
      elig[i]  = !bus.q_empty[i] && (bus.q_ready[i] || !c_top[i].inst_en);
    end
    sf = !m_valid || c_fu;
    found = 0; g = 0;
    for (int i = 0; i < NQ; i++)
      if (!found && elig[i] && m_starve[i] == LIM) begin g = i; found = 1; end
    for (int k = 0; k < NQ; k++)
      if (!found && elig[(m_ptr + k) % NQ]) begin g = (m_ptr + k) % NQ; found = 1; end
    pop = found && sf && !c_rst && !c_flush && !m_after_flush;
    exp_qre = pop ? (NQ'(1) << g) : '0;
    s_qre = bus.q_re;
    @(posedge clk);
    if (c_rst) begin
      m_valid = 0; m_slot = '0; m_qid = 0; m_count = 0; m_ptr = 0; m_after_flush = 0;
      for (int i = 0; i < NQ; i++) m_starve[i] = 0;
    end else if (c_flush) begin
      m_valid = 0; m_ptr = 0; m_after_flush = 1;
      for (int i = 0; i < NQ; i++) m_starve[i] = 0;
    end else begin
      m_after_flush = 0;
      acc = m_valid && c_fu;
      if (acc) m_count = m_count + 1;
      if (pop && c_top[g].inst_en) begin
        m_slot = c_top[g]; m_qid = g; m_valid = 1;
      end else if (acc) begin
        m_valid = 0;
      end
      if (pop) m_ptr = (g + 1) % NQ;
      for (int i = 0; i < NQ; i++) begin
        if ((pop && g == i) || !elig[i]) m_starve[i] = 0;
        else if (sf && m_starve[i] < LIM) m_starve[i] = m_starve[i] + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; cntl.flush = 0; bus.fu_ready = 1;
    drive('0, '1, '1);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (s_qre !== 4'b0000 || bus.issue_valid !== 1'b0 || issue_count !== 32'd0) begin
        n_fail++;
        $display("FAIL reset: q_re=%b valid=%b count=%0d, want 0000/0/0", s_qre, bus.issue_valid, issue_count);
      end
    end
    rst = 0;
    tick();
    n_checks++;
    if (s_qre !== 4'b0001 || bus.issue_qid !== 2'd0 || bus.issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: q_re=%b qid=%0d valid=%b, want 0001/0/1", s_qre, bus.issue_qid, bus.issue_valid);
    end
  endtask

  task automatic test_round_robin();
    rst = 1; tick(); rst = 0;
    bus.fu_ready = 1;
    for (int k = 0; k < 5; k++) begin
      drive('0, '1, '1);
      tick();
      n_checks++;
      if (s_qre !== (NQ'(1) << (k % 4)) || bus.issue_qid !== 2'(k % 4) || bus.issue_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_%0d: q_re=%b qid=%0d, want qid %0d", k, s_qre, bus.issue_qid, k % 4);
      end
    end
    drive('1, '0, '1);
    tick();
    n_checks++;
    if (issue_count !== 32'd5 || bus.issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_count: count=%0d valid=%b, want 5/0", issue_count, bus.issue_valid);
    end
  endtask

  task automatic test_backpressure();
    inst_fifo_slot_t held;
    logic [31:0] c0;
    drive(4'b1101, '1, '1);
    tick();
    held = bus.issue_slot;
    n_checks++;
    if (s_qre !== 4'b0010 || bus.issue_qid !== 2'd1 || bus.issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_issue: q_re=%b qid=%0d, want 0010/1", s_qre, bus.issue_qid);
    end
    c0 = issue_count;
    bus.fu_ready = 0;
    drive('0, '1, '1);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (s_qre !== 4'b0000 || bus.issue_slot !== held || bus.issue_qid !== 2'd1 || bus.issue_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: q_re=%b slot=%h qid=%0d, want 0000/%h/1", c, s_qre, bus.issue_slot, bus.issue_qid, held);
      end
    end
    bus.fu_ready = 1;
    tick();
    n_checks++;
    if (s_qre !== 4'b0100 || bus.issue_qid !== 2'd2 || bus.issue_valid !== 1'b1 || issue_count !== c0 + 32'd1) begin
      n_fail++;
      $display("FAIL bp_release: q_re=%b qid=%0d count=%0d, want 0100/2/%0d", s_qre, bus.issue_qid, issue_count, c0 + 1);
    end
  endtask

  task automatic test_discard();
    logic [31:0] c0;
    drive('1, '0, '1);
    tick(); tick();
    c0 = issue_count;
    drive(4'b1011, 4'b0000, 4'b1011);
    tick();
    n_checks++;
    if (s_qre !== 4'b0100 || bus.issue_valid !== 1'b0 || issue_count !== c0) begin
      n_fail++;
      $display("FAIL discard: q_re=%b valid=%b count=%0d, want 0100/0/%0d", s_qre, bus.issue_valid, issue_count, c0);
    end
    drive('0, '1, '1);
    tick();
    n_checks++;
    if (s_qre !== 4'b1000 || bus.issue_qid !== 2'd3) begin
      n_fail++;
      $display("FAIL discard_ptr: q_re=%b qid=%0d, want 1000/3", s_qre, bus.issue_qid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] c0;
    c0 = issue_count;
    cntl.flush = 1;
    tick();
    n_checks++;
    if (s_qre !== 4'b0000 || bus.issue_valid !== 1'b0 || issue_count !== c0) begin
      n_fail++;
      $display("FAIL flush: q_re=%b valid=%b count=%0d, want 0000/0/%0d", s_qre, bus.issue_valid, issue_count, c0);
    end
    cntl.flush = 0;
    tick();
    n_checks++;
    if (s_qre !== 4'b0000 || bus.issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_settle: q_re=%b valid=%b, want 0000/0", s_qre, bus.issue_valid);
    end
    tick();
    n_checks++;
    if (s_qre !== 4'b0001 || bus.issue_qid !== 2'd0 || bus.issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_restart: q_re=%b qid=%0d, want 0001/0", s_qre, bus.issue_qid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(99) == 0);
      cntl.flush   = ($urandom_range(29) == 0);
      bus.fu_ready = ($urandom_range(3) != 0);
      drive(NQ'($urandom()) & NQ'($urandom()), NQ'($urandom()), NQ'($urandom()) | NQ'($urandom()));
      tick();
      n_checks++;
      if (s_qre !== exp_qre) begin
        n_fail++;
        $display("FAIL rand_qre cyc %0d: got %b want %b", c, s_qre, exp_qre);
      end
      n_checks++;
      if (bus.issue_valid !== m_valid || bus.issue_slot !== m_slot ||
          bus.issue_qid !== 2'(m_qid) || issue_count !== m_count) begin
        n_fail++;
        $display("FAIL rand_out cyc %0d: valid=%b slot=%h qid=%0d count=%0d want %b/%h/%0d/%0d",
                 c, bus.issue_valid, bus.issue_slot, bus.issue_qid, issue_count,
                 m_valid, m_slot, m_qid, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_discard();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
